slc3_control: RTL and testbench

Instruction-sequencing control unit for the SLC-3 CPU. It sits directly upstream of `datapath` and drives every load, gate and mux-select input of the datapath from the current instruction (`IR`) and branch flag (`BEN`). It also drives memory enables with a parameterised wait count. It is a Moore state machine that runs fetch, decode and execute, and implements a PAUSE instruction that stops for the operator.

---
 rtl/slc3_pkg.sv | 64 ++++++
 rtl/slc3_wait_ctr.sv | 26 ++
 rtl/slc3_control.sv | 236 +++++++++++++++++++++++
 tb/tb_slc3_control.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: FSM states, opcodes and datapath mux/ALU encodings.
// PAUSE states exist only when SLC3_PAUSE_EN is defined.
package slc3_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_BR    = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'b0001;
  localparam logic [OPC_W-1:0] OP_JSR   = 4'b0100;
  localparam logic [OPC_W-1:0] OP_AND   = 4'b0101;
  localparam logic [OPC_W-1:0] OP_LDR   = 4'b0110;
  localparam logic [OPC_W-1:0] OP_STR   = 4'b0111;
  localparam logic [OPC_W-1:0] OP_NOT   = 4'b1001;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'b1100;
  localparam logic [OPC_W-1:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC_INC = 2'b00;
  localparam logic [1:0] PCMUX_BUS    = 2'b01;
  localparam logic [1:0] PCMUX_ADDR   = 2'b10;

  localparam logic [1:0] ADDR2_SEXT11 = 2'b00;
  localparam logic [1:0] ADDR2_SEXT9  = 2'b01;
  localparam logic [1:0] ADDR2_SEXT6  = 2'b10;
  localparam logic [1:0] ADDR2_ZERO   = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOTA = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  typedef enum logic [4:0] {
    S_HALTED,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_ALU,
    S_BR0,
    S_BR1,
    S_JMP,
    S_JSR0,
    S_JSR1,
    S_LDR0,
    S_LDR1,
    S_LDR2,
    S_STR0,
    S_STR1,
    S_STR2
`ifdef SLC3_PAUSE_EN
    , S_PAUSE1,
    S_PAUSE2
`endif
  } state_e;

  // ALU function for the three register-operate opcodes.
  function automatic logic [1:0] aluk_of(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD:  aluk_of = ALUK_ADD;
      OP_AND:  aluk_of = ALUK_AND;
      default: aluk_of = ALUK_NOTA;
    endcase
  endfunction

endpackage

// File: rtl/slc3_wait_ctr.sv
// Memory wait counter: counts 0..MEM_WAIT-1 while en is high, done on the last count.
// Clears whenever en drops or the final count is reached.
module slc3_wait_ctr #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT + 1);

  logic [CNT_W-1:0] cnt;

  assign done = en && (cnt == CNT_W'(MEM_WAIT - 1));

  always_ff @(posedge clk) begin
    if (reset || !en || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/slc3_control.sv
// SLC-3 Moore control FSM: fetch/decode/execute sequencing for the datapath.
// Define SLC3_PAUSE_EN to build the operator PAUSE instruction (opcode 1101).
module slc3_control
  import slc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        continue_i,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        LD_REG,
  output logic        LD_PC,
  output logic        LD_LED,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic        DR,
  output logic        SR1,
  output logic        SR2,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic [1:0]  ALUK,
  output logic        MIO_EN,
  output logic        Mem_OE,
  output logic        Mem_WE
);

  state_e           state;
  state_e           state_next;
  logic             wait_en;
  logic             wait_done;
  logic [OPC_W-1:0] opcode;

  assign opcode  = IR[15:12];
  assign wait_en = (state == S_FETCH2) || (state == S_LDR1) || (state == S_STR2);

  // Only the opcode and the immediate-select bit steer the sequencer.
  logic unused_ir;
  assign unused_ir = ^{IR[11:6], IR[4:0]};

`ifndef SLC3_PAUSE_EN
  logic unused_cont;
  assign unused_cont = continue_i;
`endif

  slc3_wait_ctr #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (wait_en),
    .done  (wait_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_HALTED;
    end else begin
      state <= state_next;
    end
  end

  // Next state and state-decoded controls; anything not set below is 0.
  always_comb begin
    state_next = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_PC_INC;
    DR         = 1'b0;
    SR1        = 1'b0;
    SR2        = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = ADDR2_SEXT11;
    ALUK       = ALUK_ADD;
    MIO_EN     = 1'b0;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;

    case (state)
      S_HALTED: begin
        if (run) state_next = S_FETCH1;
      end
      S_FETCH1: begin
        GatePC     = 1'b1;
        LD_MAR     = 1'b1;
        PCMUX      = PCMUX_PC_INC;
        LD_PC      = 1'b1;
        state_next = S_FETCH2;
      end
      S_FETCH2: begin
        Mem_OE = 1'b1;
        MIO_EN = 1'b1;
        if (wait_done) begin
          LD_MDR     = 1'b1;
          state_next = S_FETCH3;
        end
      end
      S_FETCH3: begin
        GateMDR    = 1'b1;
        LD_IR      = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        LD_BEN = 1'b1;
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: state_next = S_ALU;
          OP_BR:                  state_next = S_BR0;
          OP_JMP:                 state_next = S_JMP;
          OP_JSR:                 state_next = S_JSR0;
          OP_LDR:                 state_next = S_LDR0;
          OP_STR:                 state_next = S_STR0;
`ifdef SLC3_PAUSE_EN
          OP_PAUSE:               state_next = S_PAUSE1;
`endif
          default:                state_next = S_FETCH1;
        endcase
      end
      S_ALU: begin
        SR1        = 1'b1;
        SR2        = IR[5];
        DR         = 1'b0;
        GateALU    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        ALUK       = aluk_of(opcode);
        state_next = S_FETCH1;
      end
      S_BR0: begin
        state_next = BEN ? S_BR1 : S_FETCH1;
      end
      S_BR1: begin
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_SEXT9;
        PCMUX      = PCMUX_ADDR;
        LD_PC      = 1'b1;
        state_next = S_FETCH1;
      end
      S_JMP: begin
        SR1        = 1'b1;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_ZERO;
        PCMUX      = PCMUX_ADDR;
        LD_PC      = 1'b1;
        state_next = S_FETCH1;
      end
      S_JSR0: begin
        GatePC     = 1'b1;
        DR         = 1'b1;
        LD_REG     = 1'b1;
        state_next = S_JSR1;
      end
      S_JSR1: begin
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_SEXT11;
        PCMUX      = PCMUX_ADDR;
        LD_PC      = 1'b1;
        state_next = S_FETCH1;
      end
      S_LDR0: begin
        SR1        = 1'b1;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_SEXT6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        state_next = S_LDR1;
      end
      S_LDR1: begin
        Mem_OE = 1'b1;
        MIO_EN = 1'b1;
        if (wait_done) begin
          LD_MDR     = 1'b1;
          state_next = S_LDR2;
        end
      end
      S_LDR2: begin
        GateMDR    = 1'b1;
        DR         = 1'b0;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        state_next = S_FETCH1;
      end
      S_STR0: begin
        SR1        = 1'b1;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_SEXT6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        state_next = S_STR1;
      end
      S_STR1: begin
        SR1        = 1'b0;
        ALUK       = ALUK_PASS;
        GateALU    = 1'b1;
        MIO_EN     = 1'b0;
        LD_MDR     = 1'b1;
        state_next = S_STR2;
      end
      S_STR2: begin
        Mem_WE = 1'b1;
        if (wait_done) state_next = S_FETCH1;
      end
`ifdef SLC3_PAUSE_EN
      // Hold the LED display until the operator raises then releases continue.
      S_PAUSE1: begin
        LD_LED = 1'b1;
        if (continue_i) state_next = S_PAUSE2;
      end
      S_PAUSE2: begin
        if (!continue_i) state_next = S_FETCH1;
      end
`endif
      default: state_next = S_HALTED;
    endcase
  end

endmodule

// File: tb/tb_slc3_control.sv
// Directed bench for slc3_control: two instances (MEM_WAIT 2 and 3) share all inputs.
// Outputs are packed into 25-bit vectors and compared against per-state expectations.
module tb_slc3_control;

  logic        clk;
  logic        reset;
  logic        run;
  logic        cont;
  logic [15:0] IR;
  logic        BEN;
  wire  [24:0] ao;
  wire  [24:0] bo;

  int checks = 0;
  int errors = 0;

  localparam logic [24:0] B_LD_MAR    = 25'h1 << 24;
  localparam logic [24:0] B_LD_MDR    = 25'h1 << 23;
  localparam logic [24:0] B_LD_IR     = 25'h1 << 22;
  localparam logic [24:0] B_LD_BEN    = 25'h1 << 21;
  localparam logic [24:0] B_LD_CC     = 25'h1 << 20;
  localparam logic [24:0] B_LD_REG    = 25'h1 << 19;
  localparam logic [24:0] B_LD_PC     = 25'h1 << 18;
  localparam logic [24:0] B_LD_LED    = 25'h1 << 17;
  localparam logic [24:0] B_GPC       = 25'h1 << 16;
  localparam logic [24:0] B_GMDR      = 25'h1 << 15;
  localparam logic [24:0] B_GALU      = 25'h1 << 14;
  localparam logic [24:0] B_GMAR      = 25'h1 << 13;
  localparam logic [24:0] B_PCM_ADDR  = 25'h1 << 12;
  localparam logic [24:0] B_DR        = 25'h1 << 10;
  localparam logic [24:0] B_SR1       = 25'h1 << 9;
  localparam logic [24:0] B_SR2       = 25'h1 << 8;
  localparam logic [24:0] B_A1        = 25'h1 << 7;
  localparam logic [24:0] B_A2_SEXT6  = 25'h1 << 6;
  localparam logic [24:0] B_A2_SEXT9  = 25'h1 << 5;
  localparam logic [24:0] B_A2_ZERO   = 25'h3 << 5;
  localparam logic [24:0] B_ALUK_NOT  = 25'h1 << 4;
  localparam logic [24:0] B_ALUK_AND  = 25'h1 << 3;
  localparam logic [24:0] B_ALUK_PASS = 25'h3 << 3;
  localparam logic [24:0] B_MIO       = 25'h1 << 2;
  localparam logic [24:0] B_OE        = 25'h1 << 1;
  localparam logic [24:0] B_WE        = 25'h1;

  localparam logic [24:0] E_F1    = B_LD_MAR | B_LD_PC | B_GPC;
  localparam logic [24:0] E_F2    = B_MIO | B_OE;
  localparam logic [24:0] E_F2L   = B_MIO | B_OE | B_LD_MDR;
  localparam logic [24:0] E_F3    = B_GMDR | B_LD_IR;
  localparam logic [24:0] E_DEC   = B_LD_BEN;
  localparam logic [24:0] E_ADD   = B_SR1 | B_SR2 | B_GALU | B_LD_REG | B_LD_CC;
  localparam logic [24:0] E_AND   = B_SR1 | B_GALU | B_LD_REG | B_LD_CC | B_ALUK_AND;
  localparam logic [24:0] E_NOT   = B_SR1 | B_SR2 | B_GALU | B_LD_REG | B_LD_CC | B_ALUK_NOT;
  localparam logic [24:0] E_BR1   = B_A1 | B_A2_SEXT9 | B_PCM_ADDR | B_LD_PC;
  localparam logic [24:0] E_JMP   = B_SR1 | B_A2_ZERO | B_PCM_ADDR | B_LD_PC;
  localparam logic [24:0] E_JSR0  = B_GPC | B_DR | B_LD_REG;
  localparam logic [24:0] E_JSR1  = B_A1 | B_PCM_ADDR | B_LD_PC;
  localparam logic [24:0] E_MADDR = B_SR1 | B_A2_SEXT6 | B_GMAR | B_LD_MAR;
  localparam logic [24:0] E_LDR2  = B_GMDR | B_LD_REG | B_LD_CC;
  localparam logic [24:0] E_STR1  = B_ALUK_PASS | B_GALU | B_LD_MDR;
  localparam logic [24:0] E_STR2  = B_WE;
  localparam logic [24:0] E_LED   = B_LD_LED;

  slc3_control #(.MEM_WAIT(2)) u_a (
    .clk(clk), .reset(reset), .run(run), .continue_i(cont), .IR(IR), .BEN(BEN),
    .LD_MAR(ao[24]), .LD_MDR(ao[23]), .LD_IR(ao[22]), .LD_BEN(ao[21]),
    .LD_CC(ao[20]), .LD_REG(ao[19]), .LD_PC(ao[18]), .LD_LED(ao[17]),
    .GatePC(ao[16]), .GateMDR(ao[15]), .GateALU(ao[14]), .GateMARMUX(ao[13]),
    .PCMUX(ao[12:11]), .DR(ao[10]), .SR1(ao[9]), .SR2(ao[8]), .ADDR1MUX(ao[7]),
    .ADDR2MUX(ao[6:5]), .ALUK(ao[4:3]), .MIO_EN(ao[2]), .Mem_OE(ao[1]), .Mem_WE(ao[0])
  );

  slc3_control #(.MEM_WAIT(3)) u_b (
    .clk(clk), .reset(reset), .run(run), .continue_i(cont), .IR(IR), .BEN(BEN),
    .LD_MAR(bo[24]), .LD_MDR(bo[23]), .LD_IR(bo[22]), .LD_BEN(bo[21]),
    .LD_CC(bo[20]), .LD_REG(bo[19]), .LD_PC(bo[18]), .LD_LED(bo[17]),
    .GatePC(bo[16]), .GateMDR(bo[15]), .GateALU(bo[14]), .GateMARMUX(bo[13]),
    .PCMUX(bo[12:11]), .DR(bo[10]), .SR1(bo[9]), .SR2(bo[8]), .ADDR1MUX(bo[7]),
    .ADDR2MUX(bo[6:5]), .ALUK(bo[4:3]), .MIO_EN(bo[2]), .Mem_OE(bo[1]), .Mem_WE(bo[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, check bus/memory invariants.
  task automatic step();
    @(posedge clk);
    #1;
    chk("inv_a", {23'd0, 1'($countones(ao[16:13]) > 1), ao[1] & ao[0]}, 25'd0);
    chk("inv_b", {23'd0, 1'($countones(bo[16:13]) > 1), bo[1] & bo[0]}, 25'd0);
  endtask

  // Instance a (MEM_WAIT=2) from FETCH1 through DECODE.
  task automatic fetch_dec(input string tag);
    step(); chk({tag, "_f2a"}, ao, E_F2);
    step(); chk({tag, "_f2b"}, ao, E_F2L);
    step(); chk({tag, "_f3"},  ao, E_F3);
    step(); chk({tag, "_dec"}, ao, E_DEC);
  endtask

  logic [24:0] a_hist [12];
  logic [24:0] b_hist [12];
  int          b_we;

  initial begin
    reset = 1'b1; run = 1'b0; cont = 1'b0; IR = 16'h1261; BEN = 1'b0;
    step(); step();
    chk("reset_a", ao, 25'd0);
    chk("reset_b", bo, 25'd0);

    // ADD R1,R1,#1
    reset = 1'b0; run = 1'b1;
    step(); run = 1'b0;
    chk("start_a", ao, E_F1);
    chk("start_b", bo, E_F1);
    fetch_dec("add");
    step(); chk("add_alu", ao, E_ADD);
    step(); chk("add_next_f1", ao, E_F1);

    // BRnzp taken
    IR = 16'h0E05; BEN = 1'b1;
    fetch_dec("brt");
    step(); chk("brt_br0", ao, 25'd0);
    step(); chk("brt_br1", ao, E_BR1);
    step(); chk("brt_f1", ao, E_F1);

    // BR not taken
    BEN = 1'b0;
    fetch_dec("brn");
    step(); chk("brn_br0", ao, 25'd0);
    step(); chk("brn_f1", ao, E_F1);

    IR = 16'h5482;
    fetch_dec("and");
    step(); chk("and_alu", ao, E_AND);
    step(); chk("and_f1", ao, E_F1);

    IR = 16'h967F;
    fetch_dec("not");
    step(); chk("not_alu", ao, E_NOT);
    step(); chk("not_f1", ao, E_F1);

    IR = 16'h4805;
    fetch_dec("jsr");
    step(); chk("jsr0", ao, E_JSR0);
    step(); chk("jsr1", ao, E_JSR1);
    step(); chk("jsr_f1", ao, E_F1);

    IR = 16'hC1C0;
    fetch_dec("jmp");
    step(); chk("jmp", ao, E_JMP);
    step(); chk("jmp_f1", ao, E_F1);

    // Unused opcode runs as NOP
    IR = 16'hF025;
    fetch_dec("nop");
    step(); chk("nop_f1", ao, E_F1);

    IR = 16'hD0FF;
    fetch_dec("pause");
`ifdef SLC3_PAUSE_EN
    step(); chk("pause1", ao, E_LED);
    step(); chk("pause1_hold", ao, E_LED);
    step(); chk("pause1_hold2", ao, E_LED);
    cont = 1'b1;
    step(); chk("pause2", ao, 25'd0);
    step(); chk("pause2_hold", ao, 25'd0);
    cont = 1'b0;
    step(); chk("pause_f1", ao, E_F1);
`else
    step(); chk("pause_nop_f1", ao, E_F1);
`endif

    // LDR interrupted by reset mid-wait, then rerun from scratch
    IR = 16'h6442;
    fetch_dec("ldr");
    step(); chk("ldr0", ao, E_MADDR);
    step(); chk("ldr1_c0", ao, E_F2);
    reset = 1'b1;
    step(); chk("ldr_reset_a", ao, 25'd0);
    chk("ldr_reset_b", bo, 25'd0);
    reset = 1'b0; run = 1'b1;
    step(); run = 1'b0;
    chk("ldr_restart_f1", ao, E_F1);
    fetch_dec("ldr_rs");
    step(); chk("ldr_rs_ldr0", ao, E_MADDR);
    step(); chk("ldr_rs_ldr1_c0", ao, E_F2);
    step(); chk("ldr_rs_ldr1_c1", ao, E_F2L);
    step(); chk("ldr_rs_ldr2", ao, E_LDR2);
    step(); chk("ldr_rs_f1", ao, E_F1);

    // STR on both instances from a common start
    reset = 1'b1;
    step();
    reset = 1'b0; IR = 16'h7442; run = 1'b1;
    step(); run = 1'b0;
    a_hist[0] = ao; b_hist[0] = bo;
    for (int i = 1; i < 12; i++) begin
      step();
      a_hist[i] = ao; b_hist[i] = bo;
    end
    b_we = 0;
    for (int i = 0; i < 12; i++) b_we += int'(b_hist[i][0]);
    chk("str_a_f1", a_hist[0], E_F1);
    chk("str_a_str0", a_hist[5], E_MADDR);
    chk("str_a_str1", a_hist[6], E_STR1);
    chk("str_a_we0", a_hist[7], E_STR2);
    chk("str_a_we1", a_hist[8], E_STR2);
    chk("str_a_we_end", 25'(a_hist[9][0]), 25'd0);
    chk("str_b_f2_last", b_hist[3], E_F2L);
    chk("str_b_str1", b_hist[7], E_STR1);
    chk("str_b_we0", b_hist[8], E_STR2);
    chk("str_b_we1", b_hist[9], E_STR2);
    chk("str_b_we2", b_hist[10], E_STR2);
    chk("str_b_we_cycles", 25'(b_we), 25'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
